// File: rtl/sync_sched_pkg.sv
// Shared constants and width helpers for the gate fire scheduler.
// LFSR_TAPS/DEFAULT_SEED are only consumed when FIRE_RANDOM_EN is defined.
package sync_sched_pkg;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/fire_scheduler_pick.sv
// Wrap-around priority pick: first set bit of exc searching start, start+1, ... mod N.
module fire_pick
    import sync_sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  exc,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!valid && exc[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Fires at most one excited gate per CK cycle (round-robin, or LFSR start when
// FIRE_RANDOM_EN is defined) and tracks fire count, semi-modularity hazards and quiescence.
module fire_scheduler
    import sync_sched_pkg::*;
#(
    parameter int          N           = 8,
    parameter int          STALL_LIMIT = 16,
    parameter int          CNT_W       = 16,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic                 CK,
    input  logic                 RS,
    input  logic [N-1:0]         PRECAP,
    input  logic [N-1:0]         Q,
    input  logic                 HOLD,
    output logic [N-1:0]         ENA,
    output logic                 FIRED_VALID,
    output logic [idx_w(N)-1:0]  FIRED_IDX,
    output logic [CNT_W-1:0]     FIRE_CNT,
    output logic                 HAZARD,
    output logic [idx_w(N)-1:0]  HAZARD_IDX,
    output logic                 QUIESCENT
);

    localparam int IW = idx_w(N);
    localparam int SW = cnt_w(STALL_LIMIT);

    logic [N-1:0]  exc, exc_q, ena_q, dis, ena;
    logic [IW-1:0] ptr, start, pick_idx, dis_idx;
    logic          pick_valid, fire;
    logic [SW-1:0] stall, stall_nxt;

    assign exc = PRECAP ^ Q;

`ifdef FIRE_RANDOM_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = ^(lfsr & LFSR_TAPS);
    assign start   = IW'(lfsr % 16'(N));

    always_ff @(posedge CK) begin
        if (RS) lfsr <= SEED;
        else    lfsr <= {lfsr[14:0], lfsr_fb};
    end
`else
    assign start = ptr;
`endif

    fire_pick #(.N(N), .IW(IW)) u_pick (
        .exc   (exc),
        .start (start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign fire = pick_valid && !HOLD && !RS;

    always_comb begin
        ena = '0;
        if (fire) ena[pick_idx] = 1'b1;
    end

    assign ENA         = ena;
    assign FIRED_VALID = fire;
    assign FIRED_IDX   = fire ? pick_idx : '0;

    // Gate that was excited, not fired, and is no longer excited: lost excitation
    assign dis = exc_q & ~ena_q & ~exc;

    always_comb begin
        dis_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (dis[i]) dis_idx = IW'(i);
    end

    always_comb begin
        if (exc != '0)                      stall_nxt = '0;
        else if (stall >= SW'(STALL_LIMIT)) stall_nxt = SW'(STALL_LIMIT);
        else                                stall_nxt = stall + SW'(1);
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            ptr        <= '0;
            FIRE_CNT   <= '0;
            HAZARD     <= 1'b0;
            HAZARD_IDX <= '0;
            exc_q      <= '0;
            ena_q      <= '0;
            stall      <= '0;
            QUIESCENT  <= 1'b0;
        end else begin
            exc_q     <= exc;
            ena_q     <= ena;
            stall     <= stall_nxt;
            QUIESCENT <= (stall_nxt >= SW'(STALL_LIMIT));
            if (fire) begin
                ptr <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
                if (FIRE_CNT != {CNT_W{1'b1}}) FIRE_CNT <= FIRE_CNT + CNT_W'(1);
            end
            if (dis != '0 && !HAZARD) begin
                HAZARD     <= 1'b1;
                HAZARD_IDX <= dis_idx;
            end
        end
    end

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler (N=4, STALL_LIMIT=4, CNT_W=4), round-robin build.
module tb_fire_scheduler;

    localparam int N = 4;

    logic         CK = 1'b0;
    logic         RS, HOLD;
    logic [N-1:0] PRECAP, Q, ENA;
    logic         FIRED_VALID, HAZARD, QUIESCENT;
    logic [1:0]   FIRED_IDX, HAZARD_IDX;
    logic [3:0]   FIRE_CNT;

    int checks = 0;
    int errors = 0;
    int eptr;

    fire_scheduler #(.N(N), .STALL_LIMIT(4), .CNT_W(4), .SEED(16'hACE1)) dut (
        .CK(CK), .RS(RS), .PRECAP(PRECAP), .Q(Q), .HOLD(HOLD),
        .ENA(ENA), .FIRED_VALID(FIRED_VALID), .FIRED_IDX(FIRED_IDX),
        .FIRE_CNT(FIRE_CNT), .HAZARD(HAZARD), .HAZARD_IDX(HAZARD_IDX),
        .QUIESCENT(QUIESCENT)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one posedge, then settle away from the edge
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    initial begin
        RS = 1'b1; HOLD = 1'b0; PRECAP = 4'b1111; Q = 4'b0000;
        step();
        chk("rst_ena",   32'(ENA), 32'h0);
        chk("rst_fv",    32'(FIRED_VALID), 32'h0);
        chk("rst_cnt",   32'(FIRE_CNT), 32'h0);
        chk("rst_haz",   32'(HAZARD), 32'h0);
        chk("rst_hidx",  32'(HAZARD_IDX), 32'h0);
        chk("rst_quies", 32'(QUIESCENT), 32'h0);

        RS = 1'b0; #1;
        chk("first_ena", 32'(ENA), 32'b0001);
        chk("first_idx", 32'(FIRED_IDX), 32'h0);
        chk("first_fv",  32'(FIRED_VALID), 32'h1);
        step();
        chk("first_cnt", 32'(FIRE_CNT), 32'h1);
        chk("next_ena",  32'(ENA), 32'b0010);

        // round-robin over exc=1010 from ptr=0; Q nonzero to exercise the XOR
        RS = 1'b1; step(); RS = 1'b0;
        Q = 4'b0101; PRECAP = 4'b1111; #1;
        chk("rr_ena0", 32'(ENA), 32'b0010);
        step();
        chk("rr_ena1", 32'(ENA), 32'b1000);
        chk("rr_idx1", 32'(FIRED_IDX), 32'h3);
        step();
        chk("rr_ena2", 32'(ENA), 32'b0010);
        chk("rr_cnt",  32'(FIRE_CNT), 32'h2);
        chk("rr_haz",  32'(HAZARD), 32'h0);

        // gate 2 excited but not fired, then loses excitation
        Q = 4'b0000; PRECAP = 4'b0110; #1;
        chk("hz_ena", 32'(ENA), 32'b0010);
        step();
        PRECAP = 4'b0010; #1;
        chk("hz_pre", 32'(HAZARD), 32'h0);
        step();
        chk("hz_flag", 32'(HAZARD), 32'h1);
        chk("hz_idx",  32'(HAZARD_IDX), 32'h2);
        // a later hazard at gate 0 must not overwrite the index
        PRECAP = 4'b1001; HOLD = 1'b1; step();
        PRECAP = 4'b0000; step();
        chk("hz_sticky", 32'(HAZARD), 32'h1);
        chk("hz_keep",   32'(HAZARD_IDX), 32'h2);
        chk("hz_cnt",    32'(FIRE_CNT), 32'h4);
        HOLD = 1'b0;

        // quiescence
        RS = 1'b1; step(); RS = 1'b0;
        chk("rs_hz_clr", 32'(HAZARD), 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("q_3", 32'(QUIESCENT), 32'h0);
        step();
        chk("q_4", 32'(QUIESCENT), 32'h1);
        PRECAP = 4'b0100; #1;
        chk("q_ena",  32'(ENA), 32'b0100);
        chk("q_hold", 32'(QUIESCENT), 32'h1);
        step();
        chk("q_drop", 32'(QUIESCENT), 32'h0);

        // HOLD suppresses firing; ptr is now 3
        HOLD = 1'b1; PRECAP = 4'b0001; #1;
        chk("hold_ena", 32'(ENA), 32'h0);
        chk("hold_fv",  32'(FIRED_VALID), 32'h0);
        chk("hold_idx", 32'(FIRED_IDX), 32'h0);
        step(); step();
        chk("hold_cnt", 32'(FIRE_CNT), 32'h1);
        HOLD = 1'b0; #1;
        chk("rel_ena", 32'(ENA), 32'b0001);
        chk("rel_haz", 32'(HAZARD), 32'h0);

        // all excited: strict rotation from ptr=3, counter saturates at 15
        PRECAP = 4'b1111; eptr = 3; #1;
        for (int i = 0; i < 20; i++) begin
            chk("sat_rot", 32'(ENA), 32'(1 << eptr));
            step();
            eptr = (eptr + 1) % N;
        end
        chk("sat_cnt", 32'(FIRE_CNT), 32'hF);

        // reset mid-run gates ENA immediately
        RS = 1'b1; #1;
        chk("mid_rs_ena", 32'(ENA), 32'h0);
        step();
        chk("mid_rs_cnt", 32'(FIRE_CNT), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
